// File: rtl/mem_stage_pipe.sv
// EX/MEM pipeline stage for the RV32 core.
// Registers the EX result and runs the data-memory access: sized loads and
// stores over a req/ack bus, lane steering, and load sign/zero extension.
// A two-state FSM stalls upstream while a bus access is outstanding.

module mem_stage_pipe #(
  parameter int XLEN    = 32,
  parameter int REG_W   = 5,
  parameter int SKIP_X0 = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EX_valid,
  input  logic             EX_wr_en,
  input  logic             EX_mem_en,
  input  logic             EX_mem_wr,
  input  logic [2:0]       EX_funct3,
  input  logic [REG_W-1:0] EX_rd_sel,
  input  logic [XLEN-1:0]  EX_alu_val,
  input  logic [XLEN-1:0]  EX_rs2_val,
  input  logic             flush,
  output logic             stall_req,
  output logic             MEM_valid,
  output logic             MEM_wr_en,
  output logic [REG_W-1:0] MEM_rd_sel,
  output logic [XLEN-1:0]  MEM_result,
  output logic             MEM_misalign,
  output logic             MEM_fwd_en,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [3:0]       dmem_be,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_ack,
  input  logic [XLEN-1:0]  dmem_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state;

  // Details of the access in flight, kept for result formation on ack.
  logic [2:0]      pend_funct3;
  logic [XLEN-1:0] pend_addr;
  logic            pend_store;
  logic            pend_wr_en;
  logic            pend_flushed;

  logic            ex_byte;
  logic            ex_half;
  logic            ex_misalign;
  logic            ex_rd_zero;
  logic            ex_capture;
  logic            ex_access;
  logic [3:0]      ex_be;
  logic [XLEN-1:0] ex_wdata;

  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;
  logic [XLEN-1:0] load_ext;

  assign stall_req  = (state == BUSY);
  assign MEM_fwd_en = MEM_valid && MEM_wr_en && (MEM_rd_sel != '0);

  // Decode access size from funct3; unlisted encodings fall through to word.
  always_comb begin
    ex_byte     = (EX_funct3 == 3'b000) || (EX_funct3 == 3'b100);
    ex_half     = (EX_funct3 == 3'b001) || (EX_funct3 == 3'b101);
    ex_misalign = 1'b0;
    ex_be       = 4'b1111;
    ex_wdata    = EX_rs2_val;
    if (ex_byte) begin
      ex_be    = 4'b0001 << EX_alu_val[1:0];
      ex_wdata = {4{EX_rs2_val[7:0]}};
    end else if (ex_half) begin
      ex_misalign = EX_alu_val[0];
      ex_be       = 4'b0011 << EX_alu_val[1:0];
      ex_wdata    = {2{EX_rs2_val[15:0]}};
    end else begin
      ex_misalign = |EX_alu_val[1:0];
    end
    ex_rd_zero = (SKIP_X0 != 0) && (EX_rd_sel == '0);
    ex_capture = EX_valid && !flush;
    ex_access  = ex_capture && EX_mem_en && !ex_misalign;
  end

  // Pick the addressed lane out of the returned word and extend it.
  always_comb begin
    byte_lane = dmem_rdata[{pend_addr[1:0], 3'b000} +: 8];
    half_lane = dmem_rdata[{pend_addr[1], 4'b0000} +: 16];
    load_ext  = dmem_rdata;
    case (pend_funct3)
      3'b000:  load_ext = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, byte_lane};
      3'b001:  load_ext = {{(XLEN-16){half_lane[15]}}, half_lane};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, half_lane};
      default: load_ext = dmem_rdata;
    endcase
  end

  // Stage registers and bus FSM: capture every edge in IDLE, wait for ack in BUSY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      MEM_valid    <= 1'b0;
      MEM_wr_en    <= 1'b0;
      MEM_rd_sel   <= '0;
      MEM_result   <= '0;
      MEM_misalign <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      pend_funct3  <= '0;
      pend_addr    <= '0;
      pend_store   <= 1'b0;
      pend_wr_en   <= 1'b0;
      pend_flushed <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          MEM_rd_sel   <= EX_rd_sel;
          MEM_result   <= EX_alu_val;
          MEM_misalign <= ex_capture && EX_mem_en && ex_misalign;
          pend_funct3  <= EX_funct3;
          pend_addr    <= EX_alu_val;
          pend_store   <= EX_mem_wr;
          pend_wr_en   <= EX_wr_en && !EX_mem_wr && !ex_rd_zero;
          pend_flushed <= 1'b0;
          if (ex_access) begin
            state      <= BUSY;
            MEM_valid  <= 1'b0;
            MEM_wr_en  <= 1'b0;
            dmem_req   <= 1'b1;
            dmem_we    <= EX_mem_wr;
            dmem_addr  <= {EX_alu_val[XLEN-1:2], 2'b00};
            dmem_be    <= ex_be;
            dmem_wdata <= ex_wdata;
          end else begin
            MEM_valid <= ex_capture;
            MEM_wr_en <= ex_capture && EX_wr_en && !EX_mem_en && !ex_rd_zero;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            MEM_valid  <= !(pend_flushed || flush);
            MEM_wr_en  <= pend_wr_en && !(pend_flushed || flush);
            MEM_result <= pend_store ? pend_addr : load_ext;
          end else begin
            pend_flushed <= pend_flushed || flush;
          end
        end
      endcase
    end
  end

endmodule
